// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the MIPS register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR = 0;
  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_sync_rd_mux.sv
// mux_nto1_w: combinational word-wide 2**SEL_W-to-1 selector over a flat word array
module mux_nto1_w #(
  parameter int SEL_W = 5,
  parameter int DATA_W = 32
) (
  input  logic [(2**SEL_W)*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]             sel,
  output logic [DATA_W-1:0]            dout
);
  assign dout = din[DATA_W*int'(sel) +: DATA_W];
endmodule

// File: rtl/regfile_sync_rd.sv
// regfile_sync_rd: multi-read-port register file with registered reads and optional $0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module regfile_sync_rd import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);
  logic [DEPTH*DATA_W-1:0]  mem_q, mem_d;
  logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_RD-1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0]        mux_out [NUM_RD];
  logic                     wr_ok;
  assign wr_ok = we && !(ZERO_REG != 0 && waddr == ZA);
  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_port
      mux_nto1_w #(.SEL_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .din(mem_q),
        .sel(raddr[g*ADDR_W +: ADDR_W]),
        .dout(mux_out[g])
      );
    end
  endgenerate
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[DATA_W*int'(waddr) +: DATA_W] = wdata;
  end
  // Reads see the pre-edge array; $0 is masked on the read side too.
  always_comb begin
    rdata_d = rdata_q;
    rvalid_d = re;
    for (int p = 0; p < NUM_RD; p++)
      if (re[p])
`ifdef REGFILE_BYPASS_EN
        rdata_d[p*DATA_W +: DATA_W] = (ZERO_REG != 0 && raddr[p*ADDR_W +: ADDR_W] == ZA) ? '0 :
                                      (wr_ok && raddr[p*ADDR_W +: ADDR_W] == waddr) ? wdata : mux_out[p];
`else
        rdata_d[p*DATA_W +: DATA_W] = (ZERO_REG != 0 && raddr[p*ADDR_W +: ADDR_W] == ZA) ? '0 : mux_out[p];
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      rdata_q <= '0;
      rvalid_q <= '0;
    end else begin
      mem_q <= mem_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
endmodule

// File: tb/tb_regfile_sync_rd.sv
// tb_regfile_sync_rd: directed bench for regfile_sync_rd with and without the zero register
module tb_regfile_sync_rd;
  import regfile_pkg::*;
  logic clk = 0, reset_n = 0, we = 0;
  logic [4:0] waddr = '0;
  word_t wdata = '0;
  logic [1:0] re = '0;
  logic [9:0] raddr = '0;
  logic [63:0] rdata, rdata_nz;
  logic [1:0] rvalid, rvalid_nz;
  int n_cmp = 0, n_err = 0;
`ifdef REGFILE_BYPASS_EN
  localparam word_t BYP_EXP = 32'h22222222;
`else
  localparam word_t BYP_EXP = 32'h11111111;
`endif

  regfile_sync_rd #(.ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid));
  regfile_sync_rd #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_nz), .rvalid(rvalid_nz));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input word_t d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; re = 2'b11; raddr = {5'd7, 5'd7};
    tick(); tick();
    n_cmp++; if (rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_cmp++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
    reset_n = 1; re = 2'b01;
    tick();
    n_cmp++; if (rvalid !== 2'b01) begin n_err++; $display("FAIL post_reset_rvalid: got %b expected 01", rvalid); end
    n_cmp++; if (rdata[31:0] !== 32'h0) begin n_err++; $display("FAIL post_reset_addr7: got %h expected 0", rdata[31:0]); end
    re = 2'b00;
  endtask

  task automatic test_basic();
    wr(5'd5, 32'hDEADBEEF);
    re = 2'b01; raddr = {5'd0, 5'd5};
    tick();
    n_cmp++; if (rdata[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rdata: got %h expected deadbeef", rdata[31:0]); end
    n_cmp++; if (rvalid[0] !== 1'b1) begin n_err++; $display("FAIL basic_rvalid: got %b expected 1", rvalid[0]); end
    re = 2'b00;
    tick();
    n_cmp++; if (rvalid[0] !== 1'b0) begin n_err++; $display("FAIL basic_rvalid_drop: got %b expected 0", rvalid[0]); end
    n_cmp++; if (rdata[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_hold: got %h expected deadbeef", rdata[31:0]); end
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 32'h12345678);
    re = 2'b11; raddr = {5'd0, 5'd0};
    tick();
    n_cmp++; if (rdata !== 64'h0) begin n_err++; $display("FAIL zero_reg: got %h expected 0", rdata); end
    n_cmp++; if (rdata_nz !== 64'h12345678_12345678) begin n_err++; $display("FAIL nozero_reg: got %h expected 1234567812345678", rdata_nz); end
    n_cmp++; if (rvalid !== 2'b11) begin n_err++; $display("FAIL zero_rvalid: got %b expected 11", rvalid); end
    re = 2'b00;
  endtask

  task automatic test_same_cycle();
    wr(5'd9, 32'h11111111);
    we = 1; waddr = 5'd9; wdata = 32'h22222222; re = 2'b10; raddr = {5'd9, 5'd0};
    tick();
    we = 0;
    n_cmp++; if (rdata[63:32] !== BYP_EXP) begin n_err++; $display("FAIL same_cycle: got %h expected %h", rdata[63:32], BYP_EXP); end
    n_cmp++; if (rdata_nz[63:32] !== BYP_EXP) begin n_err++; $display("FAIL same_cycle_nz: got %h expected %h", rdata_nz[63:32], BYP_EXP); end
    tick();
    n_cmp++; if (rdata[63:32] !== 32'h22222222) begin n_err++; $display("FAIL next_read: got %h expected 22222222", rdata[63:32]); end
    re = 2'b00;
  endtask

  task automatic test_dual_reset();
    wr(5'd31, 32'hAAAA0000);
    wr(5'd1, 32'h0000BBBB);
    re = 2'b11; raddr = {5'd1, 5'd31};
    tick();
    n_cmp++; if (rdata !== 64'h0000BBBB_AAAA0000) begin n_err++; $display("FAIL dual_port: got %h expected 0000bbbbaaaa0000", rdata); end
    n_cmp++; if (rvalid !== 2'b11) begin n_err++; $display("FAIL dual_rvalid: got %b expected 11", rvalid); end
    reset_n = 0;
    #1;
    n_cmp++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL midreset_rvalid: got %b expected 00", rvalid); end
    n_cmp++; if (rdata !== 64'h0) begin n_err++; $display("FAIL midreset_rdata: got %h expected 0", rdata); end
    reset_n = 1;
    tick();
    n_cmp++; if (rdata !== 64'h0 || rvalid !== 2'b11) begin n_err++; $display("FAIL array_cleared: got %h/%b expected 0/11", rdata, rvalid); end
    n_cmp++; if (rdata_nz !== 64'h0) begin n_err++; $display("FAIL array_cleared_nz: got %h expected 0", rdata_nz); end
    re = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_reg();
    test_same_cycle();
    test_dual_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_sync_rd.md
Name: regfile_sync_rd

Overview:
- Parametrised multi-read-port register file for the MIPS datapath: DEPTH = 2**ADDR_W words of DATA_W bits.
- NUM_RD independent read ports, each built on a parametrised N-to-1 word multiplexer, with registered (1-cycle) read data and per-port valid.
- One synchronous write port; optional hard-wired zero register (MIPS $0).
- Sits between decode (register addresses) and the execute-stage operand latches.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 word 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  NUM_RD  per-port read enable, bit p = port p.
- raddr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  registered read data; port p occupies bits [p*DATA_W +: DATA_W].
- rvalid  out  NUM_RD  per-port read data valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, immediate, no clock needed):
  - all DEPTH words = 0.
  - rdata = 0 on all ports.
  - rvalid = 0 on all ports.
  - Deassertion is synchronised externally; the block requires no extra state.
- Write: at a rising clk edge with we=1, mem[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is dropped.
- Read (per port p, independent):
  - At a rising edge with re[p]=1: rdata_p <= sel(raddr_p) and rvalid[p] <= 1. Latency is exactly 1 cycle.
  - At a rising edge with re[p]=0: rvalid[p] <= 0 and rdata_p holds its previous value.
  - ZERO_REG=1 and raddr_p=0: rdata_p <= 0 regardless of array contents.
  - sel() is the pre-edge array contents, i.e. read-before-write, unless the optional bypass is compiled in.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W fully decoded).
- Reset asserted mid-operation: any in-flight read is discarded (rvalid=0) and the pending write is lost.
- No internal state machine beyond the array and the per-port output/valid registers. Arithmetic is none; all widths exact, no truncation.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through forwarding, per port): when re[p]=1, we=1, raddr_p==waddr, and the write is not dropped, rdata_p <= wdata (the new value).
- Not defined: rdata_p <= old mem[raddr_p]; the new value is visible on a read issued one cycle later.
- With ZERO_REG=1 and address 0, both variants return 0.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/ADDR_W constants.
  - localparam ZERO_ADDR = 0.
  - typedef word_t (logic [DATA_W-1:0]).
- One sub-module, mux_nto1_w: parameters SEL_W and DATA_W; a combinational word-wide 2**SEL_W-to-1 selector, instantiated once per read port.
- Write decode, bypass compare and output registers stay in the top.

Test Plan:
- Reset: hold reset_n=0 with re=2'b11 and clk running -> rdata=0 and rvalid=0 on both ports. Release, then read addr 7 -> 0x00000000 with rvalid=1 one cycle after re.
- Basic write/read: write 0xDEADBEEF to addr 5, next cycle re[0]=1 raddr0=5 -> cycle after, rdata0=0xDEADBEEF and rvalid[0]=1. With re dropped -> rvalid[0]=0 and rdata0 holds 0xDEADBEEF.
- Zero register: write 0x12345678 to addr 0, then read addr 0 on both ports -> both return 0x00000000. Repeat with ZERO_REG=0 -> both return 0x12345678.
- Same-cycle write/read: addr 9 holds 0x11111111; write 0x22222222 to addr 9 while port1 reads addr 9 -> 0x22222222 with REGFILE_BYPASS_EN defined, 0x11111111 without. The next read returns 0x22222222 in both variants.
- Dual-port and reset mid-read: port0 reads 31 (0xAAAA0000) and port1 reads 1 (0x0000BBBB) concurrently -> correct per-port data. Assert reset_n low between the re edge and the next edge -> rvalid=0 immediately and rdata=0; array reads 0 afterwards.
